// File: rtl/eu_insn_sequencer.sv
// rtl/eu_insn_sequencer.sv - fetch/decode/issue sequencer for the MNISC EU
// Purpose: pulls 32-bit instruction words from a valid/ready stream, decodes a
//   header plus up to MAX_ARGS argument words, issues EU ops one at a time over
//   a cmd handshake and waits for EU completion. NOP/META/END are retired
//   locally; the first error is latched with its code.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin program fetch (only from IDLE/DONE/ERROR)
//   insn_valid/ready/data    instruction word stream
//   cmd_valid/ready          EU command handshake
//   cmd_opcode/flags/nargs   decoded header of the issued op
//   cmd_args                 arg k at [32k+:32], unused args zero
//   eu_done, eu_err          EU completion pulse and its error code
//   busy, done               activity level, END-retired level
//   err_valid, err_code      sticky error flag and code
//   insn_count               headers retired since start
module eu_insn_sequencer #(
  parameter int INSN_W   = 32,
  parameter int MAX_ARGS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   insn_valid,
  output logic                   insn_ready,
  input  logic [INSN_W-1:0]      insn_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [7:0]             cmd_opcode,
  output logic [7:0]             cmd_flags,
  output logic [7:0]             cmd_nargs,
  output logic [MAX_ARGS*32-1:0] cmd_args,
  input  logic                   eu_done,
  input  logic [7:0]             eu_err,
  output logic                   busy,
  output logic                   done,
  output logic                   err_valid,
  output logic [7:0]             err_code,
  output logic [31:0]            insn_count
);
  localparam int IDX_W = $clog2(MAX_ARGS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_ARG   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_END      = 8'h01;
  localparam logic [7:0] OP_META_BAR = 8'h10;
  localparam logic [7:0] OP_META_TAG = 8'h11;
  localparam logic [7:0] OP_EU_FIRST = 8'h20;  // CONV3X3
  localparam logic [7:0] OP_EU_LAST  = 8'h25;  // GEMM

  localparam logic [7:0] ERR_NONE           = 8'h00;
  localparam logic [7:0] ERR_INVALID_OPCODE = 8'h01;
  localparam logic [7:0] ERR_INVALID_PARAM  = 8'h02;

  logic [2:0]       state;
  logic [IDX_W-1:0] arg_idx;
  logic [7:0]       hdr_op;
  logic [7:0]       hdr_nargs;
  logic             hdr_is_eu;
  logic             hdr_is_local;
  logic             cur_is_eu;
  logic             last_arg;
  logic             unused_bits;

  assign hdr_op       = insn_data[7:0];
  assign hdr_nargs    = insn_data[23:16];
  assign hdr_is_eu    = (hdr_op >= OP_EU_FIRST) && (hdr_op <= OP_EU_LAST);
  assign hdr_is_local = (hdr_op == OP_NOP) || (hdr_op == OP_END) ||
                        (hdr_op == OP_META_BAR) || (hdr_op == OP_META_TAG);
  // cmd_opcode holds the header of the instruction currently being collected
  assign cur_is_eu    = (cmd_opcode >= OP_EU_FIRST) && (cmd_opcode <= OP_EU_LAST);
  assign last_arg     = (8'(arg_idx) + 8'd1) == cmd_nargs;
  assign unused_bits  = ^insn_data[INSN_W-1:24];

  assign insn_ready = (state == S_HDR) || (state == S_ARG);
  assign cmd_valid  = (state == S_ISSUE);
  assign busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      arg_idx    <= '0;
      cmd_opcode <= '0;
      cmd_flags  <= '0;
      cmd_nargs  <= '0;
      cmd_args   <= '0;
      done       <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      insn_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_HDR;
            done       <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            insn_count <= '0;
            cmd_args   <= '0;
          end
        end
        S_HDR: begin
          if (insn_valid) begin
            cmd_opcode <= hdr_op;
            cmd_flags  <= insn_data[15:8];
            cmd_nargs  <= hdr_nargs;
            arg_idx    <= '0;
            if (!(hdr_is_eu || hdr_is_local)) begin
              state     <= S_ERROR;
              err_valid <= 1'b1;
              err_code  <= ERR_INVALID_OPCODE;
            end else if (hdr_op == OP_END) begin
              // END ignores its nargs field and consumes nothing further
              state      <= S_DONE;
              done       <= 1'b1;
              insn_count <= insn_count + 32'd1;
            end else if (hdr_nargs > 8'(MAX_ARGS)) begin
              state     <= S_ERROR;
              err_valid <= 1'b1;
              err_code  <= ERR_INVALID_PARAM;
            end else if (hdr_nargs == 8'd0) begin
              if (hdr_is_eu) begin
                state <= S_ISSUE;
              end else begin
                insn_count <= insn_count + 32'd1;
              end
            end else begin
              state <= S_ARG;
            end
          end
        end
        S_ARG: begin
          if (insn_valid) begin
            // NOP/META args are swallowed so cmd_args stays clean
            if (cur_is_eu) begin
              cmd_args[32*int'(arg_idx) +: 32] <= insn_data[31:0];
            end
            arg_idx <= arg_idx + IDX_W'(1);
            if (last_arg) begin
              if (cur_is_eu) begin
                state <= S_ISSUE;
              end else begin
                state      <= S_HDR;
                insn_count <= insn_count + 32'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eu_done) begin
            if (eu_err == ERR_NONE) begin
              state      <= S_HDR;
              insn_count <= insn_count + 32'd1;
              cmd_args   <= '0;
            end else begin
              state     <= S_ERROR;
              err_valid <= 1'b1;
              err_code  <= eu_err;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eu_insn_sequencer.sv
// tb/tb_eu_insn_sequencer.sv - randomized self-checking bench for eu_insn_sequencer
module tb_eu_insn_sequencer;
  typedef struct packed {
    logic [7:0]   op;
    logic [7:0]   fl;
    logic [7:0]   na;
    logic [511:0] args;
  } cmd_t;

  logic         clk = 1'b0;
  logic         rst, start, insn_valid, insn_ready, cmd_valid, cmd_ready;
  logic [31:0]  insn_data, insn_count;
  logic [7:0]   cmd_opcode, cmd_flags, cmd_nargs, eu_err, err_code;
  logic [511:0] cmd_args;
  logic         eu_done, busy, done, err_valid;

  eu_insn_sequencer #(.INSN_W(32), .MAX_ARGS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_flags(cmd_flags), .cmd_nargs(cmd_nargs), .cmd_args(cmd_args),
    .eu_done(eu_done), .eu_err(eu_err), .busy(busy), .done(done),
    .err_valid(err_valid), .err_code(err_code), .insn_count(insn_count)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [599:0] obs, input logic [599:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
      $error("check %s", tag);
    end
  endtask

  // ---------------- instruction feeder ----------------
  logic [31:0] feed_q[$];
  int valid_pct = 100;
  bit feed_ready_seen = 1'b0;
  int pops = 0;
  int first_pop_cyc = -1;

  initial begin
    insn_valid = 1'b0;
    insn_data  = '0;
    forever begin
      @(negedge clk);
      if (insn_valid && feed_ready_seen && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        pops++;
        if (pops == 1) first_pop_cyc = cyc;
      end
      if (feed_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
        insn_valid = 1'b1;
        insn_data  = feed_q[0];
      end else begin
        insn_valid = 1'b0;
        insn_data  = $urandom;
      end
      feed_ready_seen = insn_ready;
    end
  end

  // ---------------- EU responder / cmd monitor ----------------
  logic [7:0] err_q[$];
  cmd_t got_q[$];
  int ready_delay = 0;
  int eu_lat = 1;
  int hold = 0;
  int lat_cnt = 0;
  int first_cv_cyc = -1;
  int stab_bad = 0;
  logic [7:0] pend_err = '0;
  cmd_t snap;
  bit snap_v = 1'b0;

  initial begin
    cmd_ready = 1'b0;
    eu_done   = 1'b0;
    eu_err    = '0;
    forever begin
      @(negedge clk);
      eu_done = 1'b0;
      eu_err  = 8'($urandom);
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          eu_done = 1'b1;
          eu_err  = pend_err;
        end
      end
      if (cmd_valid) begin
        if (first_cv_cyc < 0) first_cv_cyc = cyc;
        if (snap_v && ({cmd_opcode, cmd_flags, cmd_nargs, cmd_args} !== snap)) stab_bad++;
        snap   = {cmd_opcode, cmd_flags, cmd_nargs, cmd_args};
        snap_v = 1'b1;
        if (hold >= ready_delay) cmd_ready = 1'b1;
        else begin
          cmd_ready = 1'b0;
          hold++;
        end
        if (cmd_ready) begin
          got_q.push_back(snap);
          pend_err = (err_q.size() > 0) ? err_q.pop_front() : 8'h00;
          lat_cnt  = eu_lat;
        end
      end else begin
        cmd_ready = 1'($urandom_range(1, 0));
        hold      = 0;
        snap_v    = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] prog_m[$];
  logic [7:0]  errs_m[$];
  cmd_t        exp_q[$];
  int          exp_count, exp_consumed;
  bit          exp_done, exp_errv;
  logic [7:0]  exp_code;

  function automatic bit op_eu(input logic [7:0] op);
    return (op >= 8'h20) && (op <= 8'h25);
  endfunction

  function automatic bit op_local(input logic [7:0] op);
    return (op == 8'h00) || (op == 8'h01) || (op == 8'h10) || (op == 8'h11);
  endfunction

  task automatic run_model();
    int i;
    int e;
    logic [7:0] op;
    logic [7:0] na;
    cmd_t c;
    i = 0; e = 0;
    exp_q.delete();
    exp_count = 0; exp_done = 0; exp_errv = 0; exp_code = 8'h00;
    while (i < prog_m.size()) begin
      op = prog_m[i][7:0];
      na = prog_m[i][23:16];
      c.op = op; c.fl = prog_m[i][15:8]; c.na = na; c.args = '0;
      i++;
      if (!(op_eu(op) || op_local(op))) begin exp_errv = 1; exp_code = 8'h01; break; end
      if (op == 8'h01) begin exp_count++; exp_done = 1; break; end
      if (na > 8'd16) begin exp_errv = 1; exp_code = 8'h02; break; end
      for (int k = 0; k < int'(na); k++) begin
        c.args[32*k +: 32] = prog_m[i];
        i++;
      end
      if (!op_eu(op)) begin exp_count++; continue; end
      exp_q.push_back(c);
      if (errs_m[e] != 8'h00) begin exp_errv = 1; exp_code = errs_m[e]; break; end
      e++;
      exp_count++;
    end
    exp_consumed = i;
  endtask

  task automatic gen_prog();
    int n, r;
    logic [7:0] op, na;
    prog_m.delete(); errs_m.delete();
    n = $urandom_range(5, 2);
    for (int j = 0; j < n; j++) begin
      r = $urandom_range(99, 0);
      if (r < 5) op = 8'($urandom_range(255, 38));
      else if (r < 30) op = (r < 15) ? 8'h00 : ((r < 22) ? 8'h10 : 8'h11);
      else op = 8'h20 + 8'($urandom_range(5, 0));
      r = $urandom_range(99, 0);
      na = (r < 5) ? 8'($urandom_range(20, 17)) : ((r < 15) ? 8'd16 : 8'($urandom_range(6, 0)));
      prog_m.push_back({8'($urandom), na, 8'($urandom_range(7, 0)), op});
      if (na <= 8'd16)
        for (int k = 0; k < int'(na); k++) prog_m.push_back($urandom);
      if (op_eu(op)) errs_m.push_back(($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 3)) : 8'h00);
    end
    prog_m.push_back({8'h00, 8'($urandom), 8'h00, 8'h01});
    prog_m.push_back($urandom);
    prog_m.push_back($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int vpct, input int rdelay, input int lat, input bit chk_idle);
    int n;
    run_model();
    feed_q = prog_m; err_q = errs_m; got_q.delete();
    pops = 0; first_pop_cyc = -1; first_cv_cyc = -1; stab_bad = 0;
    valid_pct = vpct; ready_delay = rdelay; eu_lat = lat;
    if (chk_idle) begin
      repeat (3) @(negedge clk);
      #1 check({tag, "_idle_noconsume"}, 600'(pops), 600'(0));
    end
    pulse_start();
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk); #1 n++;
    end
    check({tag, "_timeout"}, 600'(n < 5000), 600'(1));
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_consumed"}, 600'(pops), 600'(exp_consumed));
    check({tag, "_done"}, 600'(done), 600'(exp_done));
    check({tag, "_err_valid"}, 600'(err_valid), 600'(exp_errv));
    check({tag, "_err_code"}, 600'(err_code), 600'(exp_code));
    check({tag, "_count"}, 600'(insn_count), 600'(exp_count));
    check({tag, "_busy"}, 600'(busy), 600'(0));
    check({tag, "_ncmds"}, 600'(got_q.size()), 600'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_cmd%0d", tag, k), 600'(got_q[k]), 600'(exp_q[k]));
    check({tag, "_cmd_stable"}, 600'(stab_bad), 600'(0));
    feed_q.delete();
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_flags"}, 600'({insn_ready, cmd_valid, busy, done, err_valid}), 600'(0));
    check({tag, "_err_code"}, 600'(err_code), 600'(0));
    check({tag, "_count"}, 600'(insn_count), 600'(0));
    check({tag, "_cmd_hdr"}, 600'({cmd_opcode, cmd_flags, cmd_nargs}), 600'(0));
    check({tag, "_cmd_args"}, 600'(cmd_args), 600'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    #1 zero_checks("reset");
    rst = 1'b0;

    // CONV3X3 with 10 args, back-to-back words, EU done 5 cycles after accept
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h000A0220);
    for (int k = 1; k <= 10; k++) prog_m.push_back(32'(k));
    prog_m.push_back(32'h00000001);
    prog_m.push_back(32'hDEAD0001);
    errs_m.push_back(8'h00);
    run_prog("t1", 100, 0, 5, 1'b1);
    check("t1_latency", 600'(first_cv_cyc - first_pop_cyc + 1), 600'(11));

    // NOP(3) + META_BAR(0) + GEMM(2) + END
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00030000);
    prog_m.push_back(32'h11111111); prog_m.push_back(32'h22222222); prog_m.push_back(32'h33333333);
    prog_m.push_back(32'h00000010);
    prog_m.push_back(32'h00020525);
    prog_m.push_back(32'hAAAA0001); prog_m.push_back(32'hBBBB0002);
    prog_m.push_back(32'h00000001);
    errs_m.push_back(8'h00);
    run_prog("t2", 70, 2, 3, 1'b1);

    // invalid opcode, then restart clears the error
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00000030);
    prog_m.push_back(32'h00000001);
    run_prog("t3", 100, 0, 1, 1'b1);
    check("t3_ready_low", 600'(insn_ready), 600'(0));
    pulse_start();
    check("t3_restart_state", 600'({err_valid, err_code, busy, insn_ready}), 600'({1'b0, 8'h00, 1'b1, 1'b1}));
    check("t3_restart_count", 600'(insn_count), 600'(0));
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00050001);
    run_prog("t3b", 100, 0, 1, 1'b0);

    // nargs 17 rejected, nargs 16 accepted with all args
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00110020);
    prog_m.push_back(32'h12345678);
    run_prog("t4a", 100, 0, 1, 1'b1);
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00100720);
    for (int k = 0; k < 16; k++) prog_m.push_back($urandom);
    prog_m.push_back(32'h00000001);
    errs_m.push_back(8'h00);
    run_prog("t4b", 100, 0, 2, 1'b1);

    // cmd_ready held low 7 cycles, EU reports error 05
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00000000);
    prog_m.push_back(32'h00010123);
    prog_m.push_back(32'hCAFEF00D);
    prog_m.push_back(32'h00000001);
    errs_m.push_back(8'h05);
    run_prog("t5", 100, 7, 3, 1'b1);

    for (int r = 0; r < 8; r++) begin
      gen_prog();
      run_prog($sformatf("rnd%0d", r), $urandom_range(100, 30), $urandom_range(4, 0), $urandom_range(6, 1), 1'b1);
    end

    // reset while waiting on the EU
    prog_m.delete(); errs_m.delete();
    prog_m.push_back(32'h00000024);
    prog_m.push_back(32'h00000001);
    errs_m.push_back(8'h00);
    feed_q = prog_m; err_q = errs_m; got_q.delete();
    valid_pct = 60; ready_delay = 1; eu_lat = 40;
    pulse_start();
    n = 0;
    while (got_q.size() == 0 && n < 200) begin
      @(negedge clk); #1 n++;
    end
    check("t6_reach_wait", 600'(n < 200), 600'(1));
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 zero_checks("t6_rst");
    rst = 1'b0; lat_cnt = 0; feed_q.delete();
    repeat (3) @(negedge clk);
    #1 check("t6_stays_idle", 600'({busy, insn_ready, cmd_valid}), 600'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
